// File: rtl/bcd2binary_if.sv
// Handshake and data bundle between a BCD source and the bcd2binary converter.
// The master drives start/bcd; the slave (the converter) returns busy/done/err/binary.
// Widths follow the converter parameters so one instance serves any digit count.
interface bcd2binary_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      binary;

  modport master (
    output start,
    output bcd,
    input  busy,
    input  done,
    input  err,
    input  binary
  );

  modport slave (
    input  start,
    input  bcd,
    output busy,
    output done,
    output err,
    output binary
  );
endinterface

// File: rtl/bcd2binary.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out.
// Latency: 2*BIN_W+1 edges after start is accepted (21 for defaults); illegal digit -> 1 edge.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module bcd2binary #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input logic        clk,
  input logic        rst,
  bcd2binary_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd_r;
  logic [BIN_W-1:0]   bin_r;
  logic [CNT_W-1:0]   cnt;
  logic               err_r;
  logic               busy_r;
  logic               done_r;
  logic               err_o;
  logic [BIN_W-1:0]   binary_o;

  logic               bad_digit;
  logic [BCD_W-1:0]   bcd_adj;

  // Flag any incoming digit above 9; such an input is rejected without shifting.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Undo the double-dabble +3: every digit that reached 8 or more after the
  // right shift gets 3 taken off, each digit on its own with no borrow across.
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd8) begin
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] - 4'd3;
      end
    end
  end

  // Conversion FSM with registered busy/done/err/binary outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bcd_r    <= '0;
      bin_r    <= '0;
      cnt      <= '0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_o    <= 1'b0;
      binary_o <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bcd_r  <= bus.bcd;
            bin_r  <= '0;
            cnt    <= CNT_W'(BIN_W);
            busy_r <= 1'b1;
            err_r  <= bad_digit;
            state  <= bad_digit ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          // One bit moves from the BCD LSB into the binary MSB end.
          {bcd_r, bin_r} <= {bcd_r, bin_r} >> 1;
          cnt            <= cnt - CNT_W'(1);
          state          <= ADJUST;
        end
        ADJUST: begin
          bcd_r <= bcd_adj;
          state <= (cnt == '0) ? DONE : SHIFT;
        end
        DONE: begin
          // A legal input is fully consumed once every bit has been shifted out.
          if (!err_r) begin
            assert (bcd_r == '0);
          end
          binary_o <= err_r ? '0 : bin_r;
          err_o    <= err_r;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_o;
  assign bus.binary = binary_o;

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary: directed cases, reset abort, held start, full sweep.
// Expected results are queued at issue time and checked when done pulses.
// Checks value, err flag and exact done cycle for every conversion.
module tb_bcd2binary;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct {
    logic [9:0] bin;
    logic       err;
    int         due;
  } exp_t;

  exp_t sb[$];

  bcd2binary_if #(.DIGITS(3), .BIN_W(10)) bus ();

  bcd2binary #(.DIGITS(3), .BIN_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        check("stray_done", bus.done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("binary", bus.binary, e.bin);
        check("err", bus.err, e.err);
        check("done_cycle", cyc, e.due);
      end
    end
  end

  // Issue one request at a negedge once the converter is idle.
  task automatic issue(input logic [11:0] b, input logic [9:0] exp_bin, input logic exp_err);
    int t;
    t = 0;
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("issue_timeout", bus.busy, 0);
    bus.bcd   = b;
    bus.start = 1'b1;
    sb.push_back('{exp_bin, exp_err, cyc + (exp_err ? 2 : 22)});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int v;
    int pushes;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.bcd   = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_binary", bus.binary, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(12'h255, 10'd255, 1'b0);
    issue(12'h999, 10'd999, 1'b0);
    issue(12'h000, 10'd0,   1'b0);
    issue(12'h010, 10'd10,  1'b0);
    issue(12'h2A5, 10'd0,   1'b1);
    issue(12'h128, 10'd128, 1'b0);
    issue(12'hF00, 10'd0,   1'b1);
    issue(12'h00A, 10'd0,   1'b1);
    issue(12'h007, 10'd7,   1'b0);
    drain();

    // Abort a conversion with reset; nothing may come out afterwards.
    issue(12'h255, 10'd255, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_err", bus.err, 0);
    check("abort_binary", bus.binary, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("post_abort_busy", bus.busy, 0);
    check("post_abort_binary", bus.binary, 0);
    check("post_abort_err", bus.err, 0);

    // Hold start with bcd changing every cycle: only idle-cycle values convert.
    pushes    = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 66; i++) begin
      v       = $urandom_range(0, 999);
      bus.bcd = to_bcd(v);
      if (!bus.busy) begin
        sb.push_back('{v[9:0], 1'b0, cyc + 22});
        pushes++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("held_issues", pushes, 3);
    drain();

    // Full legal range, back to back.
    for (int k = 0; k < 1000; k++) begin
      issue(to_bcd(k), k[9:0], 1'b0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
